// File: rtl/game_state_ctrl.sv
`timescale 1ns/1ps
// game_state_ctrl: round-flow controller upstream of the end-screen colour mapper.
// Owns round state (idle/play/won/lost), score and lives, and decodes the
// registered flags that select between the play-field and end-screen mappers.
//
// Optional feature macro: GAME_HIGH_SCORE_EN (adds the high_score output).
//
// Ports:
//   Clk          in   system clock, rising-edge active
//   Reset        in   asynchronous active-high reset
//   frame_clk    in   VGA vsync (synchronous to Clk); rising edge = one frame
//   start_btn    in   start/restart key level; rising edge used
//   kill_evt     in   one-cycle pulse, enemy destroyed
//   hit_evt      in   one-cycle pulse, player hit
//   score        out  current score, zero-extended to 32 bits
//   lives        out  remaining lives
//   is_won       out  high while in WON
//   is_lost      out  high while in LOST
//   game_active  out  high while in PLAY
//   show_end     out  high in WON or LOST (end-screen mux select)
//   high_score   out  best final score since reset (GAME_HIGH_SCORE_EN only)
module game_state_ctrl #(
  parameter int unsigned WIN_SCORE   = 20,
  parameter int unsigned START_LIVES = 3,
  parameter int unsigned HOLD_FRAMES = 120,
  parameter int unsigned SCORE_MAX   = 99
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        frame_clk,
  input  logic        start_btn,
  input  logic        kill_evt,
  input  logic        hit_evt,
  output logic [31:0] score,
  output logic [2:0]  lives,
  output logic        is_won,
  output logic        is_lost,
  output logic        game_active,
  output logic        show_end
`ifdef GAME_HIGH_SCORE_EN
  ,
  output logic [31:0] high_score
`endif
);

  localparam int unsigned SCORE_W = 7;
  localparam int unsigned LIVES_W = 3;
  localparam int unsigned HOLD_W  = $clog2(HOLD_FRAMES) + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PLAY = 2'd1,
    S_WON  = 2'd2,
    S_LOST = 2'd3
  } state_t;

  state_t               state_q, state_nx;
  logic [SCORE_W-1:0]   score_q, score_nx;
  logic [LIVES_W-1:0]   lives_q, lives_nx;
  logic [HOLD_W-1:0]    hold_q, hold_nx;
  logic                 start_q, frame_q;
  logic                 start_rise, frame_rise, hold_done;
`ifdef GAME_HIGH_SCORE_EN
  logic [SCORE_W-1:0]   hs_q, hs_nx;
`endif

  // Rising-edge detection against the previous-cycle sample.
  assign start_rise = start_btn & ~start_q;
  assign frame_rise = frame_clk & ~frame_q;
  assign hold_done  = (32'(hold_q) == HOLD_FRAMES);

  // Next-state and counter update.
  always_comb begin
    state_nx = state_q;
    score_nx = score_q;
    lives_nx = lives_q;
    hold_nx  = hold_q;

    case (state_q)
      S_IDLE: begin
        if (start_rise) begin
          state_nx = S_PLAY;
          score_nx = '0;
          lives_nx = LIVES_W'(START_LIVES);
        end
      end

      S_PLAY: begin
        if (kill_evt && (32'(score_q) < SCORE_MAX)) begin
          score_nx = score_q + SCORE_W'(1);
        end
        if (hit_evt && (lives_q != '0)) begin
          lives_nx = lives_q - LIVES_W'(1);
        end
        // Losing the last life beats reaching the win score on the same cycle.
        if (hit_evt && (lives_q == LIVES_W'(1))) begin
          state_nx = S_LOST;
          hold_nx  = '0;
        end else if (kill_evt && (32'(score_nx) >= WIN_SCORE)) begin
          state_nx = S_WON;
          hold_nx  = '0;
        end
      end

      S_WON, S_LOST: begin
        if (frame_rise && !hold_done) begin
          hold_nx = hold_q + HOLD_W'(1);
        end
        if (start_rise && hold_done) begin
          state_nx = S_PLAY;
          score_nx = '0;
          lives_nx = LIVES_W'(START_LIVES);
        end
      end

      default: state_nx = S_IDLE;
    endcase
  end

`ifdef GAME_HIGH_SCORE_EN
  // Capture the final score on the cycle a round ends.
  always_comb begin
    hs_nx = hs_q;
    if ((state_q == S_PLAY) && ((state_nx == S_WON) || (state_nx == S_LOST))
        && (score_nx > hs_q)) begin
      hs_nx = score_nx;
    end
  end
`endif

  // State, counters, edge-detect history and registered output flags.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q     <= S_IDLE;
      score_q     <= '0;
      lives_q     <= LIVES_W'(START_LIVES);
      hold_q      <= '0;
      start_q     <= 1'b0;
      frame_q     <= 1'b0;
      is_won      <= 1'b0;
      is_lost     <= 1'b0;
      game_active <= 1'b0;
      show_end    <= 1'b0;
`ifdef GAME_HIGH_SCORE_EN
      hs_q        <= '0;
`endif
    end else begin
      state_q     <= state_nx;
      score_q     <= score_nx;
      lives_q     <= lives_nx;
      hold_q      <= hold_nx;
      start_q     <= start_btn;
      frame_q     <= frame_clk;
      is_won      <= (state_nx == S_WON);
      is_lost     <= (state_nx == S_LOST);
      game_active <= (state_nx == S_PLAY);
      show_end    <= (state_nx == S_WON) || (state_nx == S_LOST);
`ifdef GAME_HIGH_SCORE_EN
      hs_q        <= hs_nx;
`endif
    end
  end

  assign score = 32'(score_q);
  assign lives = lives_q;
`ifdef GAME_HIGH_SCORE_EN
  assign high_score = 32'(hs_q);
`endif

endmodule

// File: tb/tb_game_state_ctrl.sv
`timescale 1ns/1ps
// Directed self-checking bench for game_state_ctrl (default parameters).
module tb_game_state_ctrl;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic        frame_clk = 1'b0;
  logic        start_btn = 1'b0;
  logic        kill_evt = 1'b0;
  logic        hit_evt = 1'b0;
  logic [31:0] score;
  logic [2:0]  lives;
  logic        is_won, is_lost, game_active, show_end;
`ifdef GAME_HIGH_SCORE_EN
  logic [31:0] high_score;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  game_state_ctrl dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .frame_clk   (frame_clk),
    .start_btn   (start_btn),
    .kill_evt    (kill_evt),
    .hit_evt     (hit_evt),
    .score       (score),
    .lives       (lives),
    .is_won      (is_won),
    .is_lost     (is_lost),
    .game_active (game_active),
    .show_end    (show_end)
`ifdef GAME_HIGH_SCORE_EN
    ,
    .high_score  (high_score)
`endif
  );

  always #5 Clk = ~Clk;

  // Stimulus helpers: inputs change and outputs are sampled 1 ns after posedge.
  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    step();
  endtask

  task automatic press_start();
    start_btn = 1'b1;
    step();
    start_btn = 1'b0;
    step();
  endtask

  task automatic kills(input int n);
    for (int i = 0; i < n; i++) begin
      kill_evt = 1'b1;
      step();
    end
    kill_evt = 1'b0;
  endtask

  task automatic hits(input int n);
    for (int i = 0; i < n; i++) begin
      hit_evt = 1'b1;
      step();
    end
    hit_evt = 1'b0;
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      frame_clk = 1'b1;
      step();
      frame_clk = 1'b0;
      step();
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++; if (score !== 32'd0) begin n_fail++; $display("FAIL reset_score: got %0d expected 0", score); end
    n_tests++; if (lives !== 3'd3) begin n_fail++; $display("FAIL reset_lives: got %0d expected 3", lives); end
    n_tests++; if ({is_won, is_lost, game_active, show_end} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_flags: got %b expected 0000", {is_won, is_lost, game_active, show_end}); end
    // Mid-round reset must clear outputs without a clock edge.
    press_start();
    kills(5);
    n_tests++; if (score !== 32'd5) begin n_fail++; $display("FAIL pre_reset_score: got %0d expected 5", score); end
    Reset = 1'b1;
    #1;
    n_tests++; if (score !== 32'd0) begin n_fail++; $display("FAIL async_reset_score: got %0d expected 0", score); end
    n_tests++; if (game_active !== 1'b0) begin n_fail++; $display("FAIL async_reset_active: got %0d expected 0", game_active); end
    n_tests++; if (lives !== 3'd3) begin n_fail++; $display("FAIL async_reset_lives: got %0d expected 3", lives); end
    step();
    Reset = 1'b0;
    step();
  endtask

  task automatic test_idle_ignore();
    do_reset();
    kills(2);
    hits(2);
    n_tests++; if (score !== 32'd0) begin n_fail++; $display("FAIL idle_kill: got %0d expected 0", score); end
    n_tests++; if (lives !== 3'd3) begin n_fail++; $display("FAIL idle_hit: got %0d expected 3", lives); end
    n_tests++; if (game_active !== 1'b0) begin n_fail++; $display("FAIL idle_active: got %0d expected 0", game_active); end
  endtask

  task automatic test_win();
    do_reset();
    press_start();
    n_tests++; if (game_active !== 1'b1) begin n_fail++; $display("FAIL win_start_active: got %0d expected 1", game_active); end
    kills(19);
    n_tests++; if (score !== 32'd19) begin n_fail++; $display("FAIL win_score19: got %0d expected 19", score); end
    n_tests++; if (is_won !== 1'b0) begin n_fail++; $display("FAIL win_early: got %0d expected 0", is_won); end
    kills(1);
    n_tests++; if (score !== 32'd20) begin n_fail++; $display("FAIL win_score20: got %0d expected 20", score); end
    n_tests++; if ({is_won, show_end, game_active, is_lost} !== 4'b1100) begin
      n_fail++; $display("FAIL win_flags: got %b expected 1100", {is_won, show_end, game_active, is_lost}); end
    kills(1);
    hits(1);
    n_tests++; if (score !== 32'd20) begin n_fail++; $display("FAIL win_frozen_score: got %0d expected 20", score); end
    n_tests++; if (lives !== 3'd3) begin n_fail++; $display("FAIL win_frozen_lives: got %0d expected 3", lives); end
  endtask

  task automatic test_lose();
    do_reset();
    press_start();
    hits(1);
    n_tests++; if (lives !== 3'd2) begin n_fail++; $display("FAIL lose_lives2: got %0d expected 2", lives); end
    hits(1);
    n_tests++; if (lives !== 3'd1) begin n_fail++; $display("FAIL lose_lives1: got %0d expected 1", lives); end
    n_tests++; if (is_lost !== 1'b0) begin n_fail++; $display("FAIL lose_early: got %0d expected 0", is_lost); end
    hits(1);
    n_tests++; if (lives !== 3'd0) begin n_fail++; $display("FAIL lose_lives0: got %0d expected 0", lives); end
    n_tests++; if ({is_lost, show_end, game_active, is_won} !== 4'b1100) begin
      n_fail++; $display("FAIL lose_flags: got %b expected 1100", {is_lost, show_end, game_active, is_won}); end
    hits(1);
    n_tests++; if (lives !== 3'd0) begin n_fail++; $display("FAIL lose_underflow: got %0d expected 0", lives); end
  endtask

  task automatic test_simultaneous();
    do_reset();
    press_start();
    kills(19);
    hits(2);
    kill_evt = 1'b1;
    hit_evt  = 1'b1;
    step();
    kill_evt = 1'b0;
    hit_evt  = 1'b0;
    n_tests++; if (score !== 32'd20) begin n_fail++; $display("FAIL simul_score: got %0d expected 20", score); end
    n_tests++; if (lives !== 3'd0) begin n_fail++; $display("FAIL simul_lives: got %0d expected 0", lives); end
    n_tests++; if ({is_lost, is_won} !== 2'b10) begin n_fail++; $display("FAIL simul_priority: got %b expected 10", {is_lost, is_won}); end
  endtask

  task automatic test_hold_restart();
    do_reset();
    press_start();
    kills(4);
    hits(3);
    frames(50);
    press_start();
    n_tests++; if ({game_active, is_lost} !== 2'b01) begin n_fail++; $display("FAIL hold50_ignored: got %b expected 01", {game_active, is_lost}); end
    frames(69);
    press_start();
    n_tests++; if ({game_active, is_lost} !== 2'b01) begin n_fail++; $display("FAIL hold119_ignored: got %b expected 01", {game_active, is_lost}); end
    n_tests++; if (score !== 32'd4) begin n_fail++; $display("FAIL hold_score_frozen: got %0d expected 4", score); end
    frames(1);
    press_start();
    n_tests++; if ({game_active, is_lost, show_end} !== 3'b100) begin
      n_fail++; $display("FAIL hold120_restart: got %b expected 100", {game_active, is_lost, show_end}); end
    n_tests++; if (score !== 32'd0) begin n_fail++; $display("FAIL restart_score: got %0d expected 0", score); end
    n_tests++; if (lives !== 3'd3) begin n_fail++; $display("FAIL restart_lives: got %0d expected 3", lives); end
  endtask

  task automatic test_held_start();
    do_reset();
    press_start();
    hits(2);
    start_btn = 1'b1;
    step();
    hits(1);
    frames(125);
    n_tests++; if ({game_active, is_lost} !== 2'b01) begin n_fail++; $display("FAIL held_start_restart: got %b expected 01", {game_active, is_lost}); end
    start_btn = 1'b0;
    step();
    press_start();
    n_tests++; if (game_active !== 1'b1) begin n_fail++; $display("FAIL fresh_start: got %0d expected 1", game_active); end
  endtask

`ifdef GAME_HIGH_SCORE_EN
  task automatic test_high_score();
    do_reset();
    n_tests++; if (high_score !== 32'd0) begin n_fail++; $display("FAIL hs_reset: got %0d expected 0", high_score); end
    press_start();
    kills(7);
    hits(3);
    n_tests++; if (high_score !== 32'd7) begin n_fail++; $display("FAIL hs_round1: got %0d expected 7", high_score); end
    frames(120);
    press_start();
    kills(20);
    n_tests++; if (high_score !== 32'd20) begin n_fail++; $display("FAIL hs_round2: got %0d expected 20", high_score); end
    frames(120);
    press_start();
    kills(3);
    hits(3);
    n_tests++; if (high_score !== 32'd20) begin n_fail++; $display("FAIL hs_round3: got %0d expected 20", high_score); end
  endtask
`endif

  initial begin
    #1;
    test_reset();
    test_idle_ignore();
    test_win();
    test_lose();
    test_simultaneous();
    test_hold_restart();
    test_held_start();
`ifdef GAME_HIGH_SCORE_EN
    test_high_score();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
